count_sequence_checker: RTL and testbench
=========================================

Name: count_sequence_checker

Overview:
- Monitor that sits on the output side of an up/down counter instance, the consumer end of the counter's en/out interface.
- Each cycle it samples the counter's enable, reset and count value, predicts the next count, and checks the counter actually produced it.
- It acquires lock after a run of correct steps and reports mismatches, wrap-arounds and error statistics.
- Used in bring-up tops and regression benches alongside counter instances.

Parameters:
- N, 8: width of the monitored count value (must match the counter's N).
- DOWN, 0: 0 = counter increments on en, 1 = counter decrements on en.
- LOCK_COUNT, 4: consecutive correct steps needed to enter LOCK; legal range 1..255.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset of this block.
- src_rstn  input  1  reset seen by the monitored counter (active-low).
- src_en  input  1  enable seen by the monitored counter.
- count_in  input  N  monitored counter output.
- clr_stats  input  1  synchronous clear of err_count, err_expected and err_actual.
- locked  output  1  high while the FSM is in LOCK.
- err_pulse  output  1  one-cycle pulse per mismatch detected in LOCK.
- wrap_pulse  output  1  one-cycle pulse per correct wrap step detected in LOCK.
- err_count  output  ERR_CNT_W  saturating count of mismatches in LOCK.
- err_expected  output  N  predicted value at the most recent error.
- err_actual  output  N  observed value at the most recent error.

Behaviour:
- Clock, reset and reset values
  - Clock is clk; reset is rstn, synchronous, active-low.
  - On reset, all outputs and registers go to 0 and the FSM goes to IDLE.
- Sampling
  - Every cycle the block registers prev_count <= count_in, prev_en <= src_en, prev_rst <= ~src_rstn.
- Prediction, valid from the second cycle after reset
  - If prev_rst: expected = 0.
  - Else if prev_en: expected = prev_count + 1 (DOWN=0) or prev_count - 1 (DOWN=1), modulo 2^N.
  - Else: expected = prev_count.
  - Source reset has priority over enable, matching the counter.
- Step result
  - match = (count_in == expected).
  - wrap_step = match AND !prev_rst AND prev_en AND (DOWN=0: prev_count all ones; DOWN=1: prev_count == 0).
- FSM
  - IDLE: no previous sample yet; always moves to ACQ next cycle with no check performed.
  - ACQ: on match, good_cnt++; when good_cnt reaches LOCK_COUNT, go to LOCK and clear good_cnt. On mismatch, good_cnt = 0 and stay in ACQ; no error is reported.
  - LOCK: on match stay. On mismatch, go to ACQ with good_cnt = 0, assert err_pulse, increment err_count, load err_expected = expected and err_actual = count_in.
- Output timing
  - All outputs are registered.
  - err_pulse and wrap_pulse are high in the cycle after the offending or wrapping count_in is presented.
  - locked rises in the cycle after the LOCK_COUNT-th match and falls in the cycle after a mismatch.
  - wrap_pulse is only asserted while in LOCK, including the cycle that exits LOCK only if that step matched (so effectively never together with err_pulse).
- err_count
  - Saturates at 2^ERR_CNT_W - 1; further errors still pulse err_pulse and update err_expected/err_actual.
- clr_stats
  - Clears err_count, err_expected and err_actual next cycle; the FSM is not affected.
  - If clr_stats and an error occur in the same cycle: err_count = 1, and err_expected/err_actual take the new error values.
- Arithmetic
  - All prediction arithmetic is N bits, wrap-around modulo 2^N, with no carry out.
- Mid-operation events
  - rstn low mid-operation: immediate return to reset state next edge; lock is lost.
  - Counter held in reset (src_rstn low) while count_in == 0 counts as matching steps; the checker can lock on a counter sitting in reset.

Test Plan:
- Basic lock and wrap (N=2, DOWN=0, LOCK_COUNT=4): rstn released, src_rstn low 2 cycles, then src_en=1 continuously with a correct counter giving 0,1,2,3,0,1 → locked high after 4 matches; wrap_pulse single cycle one cycle after the 3→0 step; err_count=0.
- Hold on enable low (N=2, DOWN=0, LOCK_COUNT=4): once locked, src_en=0 for 5 cycles with count_in held at 2 → locked stays high; no pulses.
- Single error injection (N=2, DOWN=0, LOCK_COUNT=4): locked, previous count 1 with prev_en=1, force count_in=3 instead of 2 → err_pulse one cycle; err_count=1; err_expected=2; err_actual=3; locked low; locked returns after 4 further correct steps.
- Down mode wrap (N=8, DOWN=1): count 2,1,0,255,254 with en=1 → wrap_pulse after the 0→255 step only; no errors.
- Saturation and clear (ERR_CNT_W=2): 5 errors, each followed by relock → err_count 1,2,3,3,3; clr_stats alone → 0; clr_stats in the same cycle as an error → 1.
- Source reset priority: locked, src_rstn=0 and src_en=1 with count_in→0 next cycle → no error; count_in=5 instead → err_pulse; err_expected=0.

Source files
------------

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - lock/mismatch/wrap monitor for an up/down counter
module count_sequence_checker #(
  parameter int N          = 8,
  parameter int DOWN       = 0,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 src_rstn,
  input  logic                 src_en,
  input  logic [N-1:0]         count_in,
  input  logic                 clr_stats,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [N-1:0]         err_expected,
  output logic [N-1:0]         err_actual
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  // good_cnt only ever needs to reach LOCK_COUNT-1 before the lock transition
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);

  logic [1:0]   state;
  logic [1:0]   next_state;
  logic [7:0]   good_cnt;
  logic [7:0]   good_cnt_next;

  logic [N-1:0] prev_count;
  logic         prev_en;
  logic         prev_rst;

  logic [N-1:0] expected;
  logic         match;
  logic         wrap_step;
  logic         err_hit;
  logic         wrap_hit;

  // Predict this cycle's count from last cycle's counter inputs; source reset wins over enable
  always_comb begin
    expected = prev_count;
    if (prev_rst) begin
      expected = '0;
    end else if (prev_en) begin
      expected = (DOWN != 0) ? prev_count - N'(1) : prev_count + N'(1);
    end
  end

  assign match     = (count_in == expected);
  assign wrap_step = match && !prev_rst && prev_en &&
                     ((DOWN != 0) ? (prev_count == '0) : (prev_count == '1));

  // Register the previous counter sample and the FSM state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      good_cnt   <= '0;
      prev_count <= '0;
      prev_en    <= 1'b0;
      prev_rst   <= 1'b0;
    end else begin
      state      <= next_state;
      good_cnt   <= good_cnt_next;
      prev_count <= count_in;
      prev_en    <= src_en;
      prev_rst   <= ~src_rstn;
    end
  end

  // Next-state decision: IDLE has no valid previous sample, so no check is made there
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = ACQ;
      ACQ:     if (match && good_cnt == LOCK_LAST) next_state = LOCK;
      LOCK:    if (!match) next_state = ACQ;
      default: next_state = IDLE;
    endcase
  end

  // Per-state outputs: good-step counting in ACQ, error and wrap detection in LOCK
  always_comb begin
    good_cnt_next = good_cnt;
    err_hit       = 1'b0;
    wrap_hit      = 1'b0;
    case (state)
      ACQ: begin
        if (!match || good_cnt == LOCK_LAST) good_cnt_next = '0;
        else                                 good_cnt_next = good_cnt + 8'd1;
      end
      LOCK: begin
        good_cnt_next = '0;
        err_hit       = !match;
        wrap_hit      = wrap_step;
      end
      default: good_cnt_next = '0;
    endcase
  end

  // Registered status outputs and error statistics; a new error overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      locked     <= (next_state == LOCK);
      err_pulse  <= err_hit;
      wrap_pulse <= wrap_hit;
      if (err_hit) begin
        err_expected <= expected;
        err_actual   <= count_in;
        if (clr_stats)            err_count <= ERR_CNT_W'(1);
        else if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      end else if (clr_stats) begin
        err_count    <= '0;
        err_expected <= '0;
        err_actual   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - scoreboard bench for count_sequence_checker
module tb_count_sequence_checker;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       src_rstn = 1'b0;
  logic       src_en = 1'b0;
  logic       clr_stats = 1'b0;
  logic [1:0] count_a = '0;
  logic [7:0] count_b = '0;

  logic       locked_a, err_pulse_a, wrap_pulse_a;
  logic [1:0] err_count_a, err_expected_a, err_actual_a;
  logic       locked_b, err_pulse_b, wrap_pulse_b;
  logic [7:0] err_count_b, err_expected_b, err_actual_b;

  count_sequence_checker #(.N(2), .DOWN(0), .LOCK_COUNT(4), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rstn(rstn), .src_rstn(src_rstn), .src_en(src_en),
    .count_in(count_a), .clr_stats(clr_stats),
    .locked(locked_a), .err_pulse(err_pulse_a), .wrap_pulse(wrap_pulse_a),
    .err_count(err_count_a), .err_expected(err_expected_a), .err_actual(err_actual_a)
  );

  count_sequence_checker #(.N(8), .DOWN(1), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rstn(rstn), .src_rstn(src_rstn), .src_en(src_en),
    .count_in(count_b), .clr_stats(clr_stats),
    .locked(locked_b), .err_pulse(err_pulse_b), .wrap_pulse(wrap_pulse_b),
    .err_count(err_count_b), .err_expected(err_expected_b), .err_actual(err_actual_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit has_prev;
    bit pen;
    bit prst;
    bit lck;
    bit errp;
    bit wrapp;
    int pc;
    int streak;
    int ecnt;
    int eexp;
    int eact;
  } mstate_t;

  typedef struct {
    logic [26:0] a;
    logic [26:0] b;
  } exp_t;

  exp_t    sb[$];
  mstate_t ma, mb;
  int      ctr_a = 0;
  int      ctr_b = 0;
  int      errors = 0;
  int      checks = 0;
  int      n_err_a = 0;
  int      n_wrap_a = 0;
  int      n_wrap_b = 0;
  bit      stim_done = 1'b0;

  // Reference: what a checker watching this sample stream should report after the clock edge
  function automatic mstate_t mstep(mstate_t s, int n, bit down, int lockc, int ew,
                                    bit r, bit sr, bit en, bit clr, int cnt);
    mstate_t o;
    int modv;
    int expv;
    bit ok;
    o = s;
    modv = 1 << n;
    o.errp = 0;
    o.wrapp = 0;
    if (!r) begin
      o = '{default: 0};
      return o;
    end
    if (s.has_prev) begin
      if (s.prst)     expv = 0;
      else if (s.pen) expv = down ? (s.pc + modv - 1) % modv : (s.pc + 1) % modv;
      else            expv = s.pc;
      ok = (cnt == expv);
      if (s.lck) begin
        if (ok) begin
          o.wrapp = !s.prst && s.pen && (s.pc == (down ? 0 : modv - 1));
        end else begin
          o.lck = 0;
          o.streak = 0;
          o.errp = 1;
          o.ecnt = (s.ecnt < (1 << ew) - 1) ? s.ecnt + 1 : s.ecnt;
          o.eexp = expv;
          o.eact = cnt;
        end
      end else if (ok) begin
        o.streak = s.streak + 1;
        if (o.streak == lockc) begin
          o.lck = 1;
          o.streak = 0;
        end
      end else begin
        o.streak = 0;
      end
    end
    if (clr) begin
      if (o.errp) o.ecnt = 1;
      else begin
        o.ecnt = 0;
        o.eexp = 0;
        o.eact = 0;
      end
    end
    o.has_prev = 1;
    o.pc = cnt;
    o.pen = en;
    o.prst = !sr;
    return o;
  endfunction

  function automatic logic [26:0] pack(mstate_t s);
    return {s.lck, s.errp, s.wrapp, 8'(s.ecnt), 8'(s.eexp), 8'(s.eact)};
  endfunction

  // One cycle: score what the last edge sampled, then present new counter inputs
  task automatic step(input bit r, input bit sr, input bit en, input bit clr,
                      input bit bad_a, input bit bad_b);
    exp_t e;
    @(posedge clk);
    #1;
    ma = mstep(ma, 2, 1'b0, 4, 2, rstn, src_rstn, src_en, clr_stats, int'(count_a));
    mb = mstep(mb, 8, 1'b1, 3, 8, rstn, src_rstn, src_en, clr_stats, int'(count_b));
    e.a = pack(ma);
    e.b = pack(mb);
    sb.push_back(e);
    if (ma.errp) n_err_a++;
    if (ma.wrapp) n_wrap_a++;
    if (mb.wrapp) n_wrap_b++;
    rstn      = r;
    src_rstn  = sr;
    src_en    = en;
    clr_stats = clr;
    count_a   = bad_a ? 2'(ctr_a) ^ 2'($urandom_range(1, 3)) : 2'(ctr_a);
    count_b   = bad_b ? 8'(ctr_b) ^ 8'($urandom_range(1, 255)) : 8'(ctr_b);
    ctr_a = !sr ? 0 : (en ? (ctr_a + 1) % 4 : ctr_a);
    ctr_b = !sr ? 0 : (en ? (ctr_b + 255) % 256 : ctr_b);
  endtask

  task automatic good(input int cycles, input bit en);
    for (int i = 0; i < cycles; i++) step(1, 1, en, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge
  initial begin : monitor
    exp_t e;
    logic [26:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {locked_a, err_pulse_a, wrap_pulse_a, 6'b0, err_count_a,
               6'b0, err_expected_a, 6'b0, err_actual_a};
        checks++;
        if (got !== e.a) begin
          errors++;
          $display("FAIL dut_a_outputs t=%0t got=%h want=%h", $time, got, e.a);
        end
        got = {locked_b, err_pulse_b, wrap_pulse_b, err_count_b, err_expected_b, err_actual_b};
        checks++;
        if (got !== e.b) begin
          errors++;
          $display("FAIL dut_b_outputs t=%0t got=%h want=%h", $time, got, e.b);
        end
      end
    end
  end

  initial begin : stimulus
    ma = '{default: 0};
    mb = '{default: 0};
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    good(10, 1);
    good(5, 0);
    step(1, 1, 1, 0, 1, 0);
    good(6, 1);
    step(1, 0, 1, 0, 0, 0);
    good(6, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    good(6, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1, 0, 1, 0);
      good(6, 1);
    end
    step(1, 1, 1, 1, 0, 0);
    good(6, 1);
    step(1, 1, 1, 1, 1, 0);
    good(6, 1);
    good(300, 1);
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 200) != 0, ($urandom % 20) != 0, ($urandom % 4) != 0,
           ($urandom % 25) == 0, ($urandom % 30) == 0, ($urandom % 30) == 0);
    end
    good(3, 1);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard;
    guard = 0;
    while (!stim_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!stim_done || sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain done=%0d pending=%0d want done=1 pending=0",
               stim_done, sb.size());
    end
    checks++;
    if (n_err_a < 5 || n_wrap_a == 0 || n_wrap_b == 0) begin
      errors++;
      $display("FAIL scenario_reach errs_a=%0d wraps_a=%0d wraps_b=%0d want >=5,>0,>0",
               n_err_a, n_wrap_a, n_wrap_b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
